// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int INST_W = 32;
    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry FIFO, zero latency to head; push+pop legal at any count incl. full.
// Flush empties in one cycle; push into a full queue without a pop is dropped.
module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // A full queue can still accept a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one RAM read in flight, issue-to-out_valid 2 cycles; stalls issue when queue+in-flight is full.
// Redirect flushes everything; IFETCH_BYTE_SWAP_EN byte-reverses instructions at enqueue.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = INST_W,
    parameter int QUEUE_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int QW = DATA_WIDTH + ADDR_WIDTH;
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CW:0]           occupancy;
    logic [DATA_WIDTH-1:0] enq_inst;
    logic [QW-1:0]         head_dat;
    logic [CW-1:0]         q_count;
    logic                  q_full;
    logic                  q_empty;

    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};

    // Issue follows the next state so the first word lands two cycles after reset release.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue   = 1'b0;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RUN && !redir_valid && !q_full &&
            occupancy < (CW+1)'(QUEUE_DEPTH)) begin
            issue = 1'b1;
        end
        if (redir_valid) begin
            pc_d = {redir_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= ADDR_WIDTH'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

`ifdef IFETCH_BYTE_SWAP_EN
    always_comb begin
        enq_inst = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            enq_inst[8*i +: 8] = mem_dout[DATA_WIDTH-8-8*i +: 8];
        end
    end
`else
    assign enq_inst = mem_dout;
`endif

    // A response arriving alongside a redirect belongs to the old stream and is dropped.
    assign push      = inflight_q && !redir_valid;
    assign out_valid = !q_empty && !redir_valid;
    assign pop       = out_valid && out_ready;

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i ({enq_inst, inflight_pc_q}),
        .pop_i      (pop),
        .flush_i    (redir_valid),
        .head_dat_o (head_dat),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    assign mem_addr = pc_q;
    assign out_inst = head_dat[QW-1:ADDR_WIDTH];
    assign out_pc   = head_dat[ADDR_WIDTH-1:0];

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Params: ADDR_WIDTH, 16, byte-address width; DATA_WIDTH, 32, instruction word width; QUEUE_DEPTH, 4, fetch queue entries (power of 2, >=2); RESET_PC, 0, PC after reset.
REQ-002 clk  in  1  single clock, all state on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 en  in  1  fetch enable; 0 freezes issue, queue still drains.
REQ-005 mem_addr  out  ADDR_WIDTH  byte address to instruction RAM read port.
REQ-006 mem_dout  in  DATA_WIDTH  RAM read data; byte at mem_addr in bits [31:24].
REQ-007 redir_valid  in  1  redirect request (branch/jump).
REQ-008 redir_pc  in  ADDR_WIDTH  redirect target.
REQ-009 out_valid  out  1  instruction available to decode.
REQ-010 out_ready  in  1  decode accepts; transfer when out_valid && out_ready.
REQ-011 out_inst  out  DATA_WIDTH  instruction word.
REQ-012 out_pc  out  ADDR_WIDTH  byte address of out_inst.

Function
REQ-013 RAM contract: address driven in cycle N yields data on mem_dout in cycle N+1; at most one fetch in flight.
REQ-014 FSM states IDLE, RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; redirect allowed in either state.
REQ-015 mem_addr = pc combinationally; in RUN, a fetch issues iff (queue count + in-flight) < QUEUE_DEPTH and redir_valid=0.
REQ-016 On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 modulo 2^ADDR_WIDTH (0xFFFC wraps to 0x0000).
REQ-017 Cycle after issue: mem_dout and inflight_pc are written to queue tail; issue-to-out_valid latency 2 cycles with empty queue.
REQ-018 Queue FIFO, order preserved; out_valid = (count != 0) && !redir_valid; out_inst/out_pc from head.
REQ-019 Simultaneous push and pop at any count shall keep count unchanged; pop from full and push same cycle allowed.
REQ-020 Redirect: on redir_valid, queue cleared, in-flight response discarded next cycle, pc<=redir_pc with bits [1:0] forced 0; no pop occurs that cycle.
REQ-021 Redirect has priority over issue, push and pop in the same cycle; back-to-back redirects: last wins.
REQ-022 en=0 mid-operation: pending in-flight response still enqueued; no new issue.
REQ-023 out_inst stable while out_valid && !out_ready.

Reset
REQ-024 On rst: state=IDLE, pc=RESET_PC, inflight=0, queue empty, out_valid=0; mem_addr=RESET_PC; out_inst, out_pc = 0 (head storage zeroed).
REQ-025 rst overrides redir_valid and any in-flight fetch; that response shall not be enqueued.

Configuration
REQ-026 Macro IFETCH_BYTE_SWAP_EN defined: out_inst = {mem_dout[7:0], [15:8], [23:16], [31:24]} (little-endian instruction); undefined: out_inst = mem_dout unchanged.
REQ-027 Swap applied at enqueue; no effect on timing or pc.

Structure
REQ-028 Shared package ifetch_pkg holds FSM state enum, instruction-width constant, and PC increment constant 4.
REQ-029 Queue implemented as sub-module fetch_queue (parameterised width/depth, push/pop/flush, count, full/empty).
REQ-030 ifetch connects to ram port a only; no writes.

Verification
REQ-031 Reset, en=1, out_ready=1, RAM words at 0,4,8 -> out_pc 0,4,8 on consecutive cycles starting cycle 2 after reset release.
REQ-032 out_ready=0 for 10 cycles -> exactly 4 entries queued, mem_addr stops at 0x10, no issue; ready=1 -> pcs 0,4,8,C then 0x10.
REQ-033 redir_valid with redir_pc=0x0102 while fetch in flight -> queue empties, next out_pc=0x0100, stale in-flight word never appears.
REQ-034 pc=0xFFFC -> next fetch address 0x0000, out_pc sequence FFFC,0000.
REQ-035 mem_dout=0x13000093 with IFETCH_BYTE_SWAP_EN -> out_inst=0x93000013; without -> 0x13000093.
REQ-036 rst asserted same cycle as redirect and a pending fetch -> next cycle pc=RESET_PC, out_valid=0, queue empty.
